// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with FIFO-buffered load
// results onto the single register-file write port, with an age limit that
// forces the oldest load through, plus pending-write lookups for decode.
module writeback_arbiter #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        aluValid,
    input  logic [4:0]  aluReg,
    input  logic [31:0] aluData,
    output logic        aluStall,

    input  logic        loadValid,
    input  logic [4:0]  loadReg,
    input  logic [31:0] loadData,
    output logic        loadReady,

    output logic [31:0] writeData,
    output logic [4:0]  writeReg,
    output logic        writeEnable,

    input  logic [4:0]  queryReg1,
    input  logic [4:0]  queryReg2,
    output logic        queryHit1,
    output logic        queryHit2
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(DEPTH);

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } loadEntryT;

    loadEntryT          fifo [DEPTH];
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   countNext;
    logic [WAIT_W-1:0]  waitCount;
    logic [PTR_W-1:0]   pushIdx;
    logic               push;
    logic               pop;
    logic               aluTake;
    logic               hit1;
    logic               hit2;

    // Handshake and arbitration decisions for this cycle
    assign loadReady = !reset && (count < CNT_W'(DEPTH));
    assign aluStall  = !reset && (count != '0) && (waitCount >= WAIT_W'(MAX_WAIT));
    assign push      = loadValid && loadReady;
    assign aluTake   = aluValid && !aluStall;
    assign pop       = !aluTake && (count != '0);
    assign countNext = count + CNT_W'(push) - CNT_W'(pop);
    // A simultaneous pop shifts everything down one slot before the new entry lands
    assign pushIdx   = pop ? PTR_W'(count - CNT_W'(1)) : PTR_W'(count);

    // Shift-register FIFO storage; slot 0 is always the head
    always_ff @(posedge clk) begin
        if (pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                fifo[i] <= fifo[i + 1];
            end
        end
        if (push) begin
            fifo[pushIdx] <= {loadReg, loadData};
        end
    end

    // Write-port registers, occupancy and head-age tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            writeEnable <= 1'b0;
            writeReg    <= '0;
            writeData   <= '0;
            count       <= '0;
            waitCount   <= '0;
        end else begin
            count <= countNext;

            if (aluTake) begin
                writeEnable <= (aluReg != '0);
                writeReg    <= aluReg;
                writeData   <= (aluReg != '0) ? aluData : '0;
            end else if (pop) begin
                writeEnable <= (fifo[0].rd != '0);
                writeReg    <= fifo[0].rd;
                writeData   <= (fifo[0].rd != '0) ? fifo[0].data : '0;
            end else begin
                writeEnable <= 1'b0;
            end

            if ((countNext == '0) || pop) begin
                waitCount <= '0;
            end else if (aluTake && (count != '0) && (waitCount != '1)) begin
                waitCount <= waitCount + WAIT_W'(1);
            end
        end
    end

    // Pending-write lookup against buffered loads and the write in flight
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (CNT_W'(i) < count) begin
                if (fifo[i].rd == queryReg1) hit1 = 1'b1;
                if (fifo[i].rd == queryReg2) hit2 = 1'b1;
            end
        end
        if (writeEnable && (writeReg == queryReg1)) hit1 = 1'b1;
        if (writeEnable && (writeReg == queryReg2)) hit2 = 1'b1;
        queryHit1 = !reset && (queryReg1 != '0) && hit1;
        queryHit2 = !reset && (queryReg2 != '0) && hit2;
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected writes are queued by the
// stimulus and a negedge monitor checks every write the DUT issues.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        aluValid;
    logic [4:0]  aluReg;
    logic [31:0] aluData;
    logic        aluStall;
    logic        loadValid;
    logic [4:0]  loadReg;
    logic [31:0] loadData;
    logic        loadReady;
    logic [31:0] writeData;
    logic [4:0]  writeReg;
    logic        writeEnable;
    logic [4:0]  queryReg1;
    logic [4:0]  queryReg2;
    logic        queryHit1;
    logic        queryHit2;

    int          total  = 0;
    int          passed = 0;
    logic [36:0] sb [$];

    always #5 clk = ~clk;

    writeback_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .aluValid   (aluValid),
        .aluReg     (aluReg),
        .aluData    (aluData),
        .aluStall   (aluStall),
        .loadValid  (loadValid),
        .loadReg    (loadReg),
        .loadData   (loadData),
        .loadReady  (loadReady),
        .writeData  (writeData),
        .writeReg   (writeReg),
        .writeEnable(writeEnable),
        .queryReg1  (queryReg1),
        .queryReg2  (queryReg2),
        .queryHit1  (queryHit1),
        .queryHit2  (queryHit2)
    );

    task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every issued write must be the next expected one
    always @(negedge clk) begin
        if (writeEnable === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: got reg %0d data 0x%0h, required no write",
                         writeReg, writeData);
            end else begin
                check("write_order", {writeReg, writeData}, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; aluValid = 1'b0; aluReg = '0; aluData = '0;
        loadValid = 1'b0; loadReg = '0; loadData = '0;
        queryReg1 = 5'd5; queryReg2 = 5'd6;

        // Reset then idle
        tick(); tick();
        @(negedge clk);
        check("rst_we",      37'(writeEnable), 37'(0));
        check("rst_wreg",    37'(writeReg),    37'(0));
        check("rst_wdata",   37'(writeData),   37'(0));
        check("rst_ready",   37'(loadReady),   37'(0));
        check("rst_stall",   37'(aluStall),    37'(0));
        check("rst_hit1",    37'(queryHit1),   37'(0));
        tick(); reset = 1'b0;
        @(negedge clk);
        check("idle_ready",  37'(loadReady),   37'(1));
        check("idle_stall",  37'(aluStall),    37'(0));
        check("idle_we",     37'(writeEnable), 37'(0));

        // Single ALU write
        sb.push_back({5'd5, 32'hDEADBEEF});
        tick(); aluValid = 1'b1; aluReg = 5'd5; aluData = 32'hDEADBEEF;
        tick(); aluValid = 1'b0;
        @(negedge clk);
        check("alu_we",      37'(writeEnable), 37'(1));
        check("alu_wreg",    37'(writeReg),    37'(5));
        check("alu_wdata",   37'(writeData),   37'(32'hDEADBEEF));
        check("alu_hit1",    37'(queryHit1),   37'(1));
        check("alu_hit2",    37'(queryHit2),   37'(0));
        tick();
        @(negedge clk);
        check("alu_we_off",  37'(writeEnable), 37'(0));

        // Load fill and drain under ALU traffic
        sb.push_back({5'd1, 32'h1000_0001});
        sb.push_back({5'd2, 32'h1000_0002});
        sb.push_back({5'd3, 32'h1000_0003});
        sb.push_back({5'd7, 32'h11});
        sb.push_back({5'd8, 32'h22});
        sb.push_back({5'd9, 32'h33});
        tick(); aluValid = 1'b1; aluReg = 5'd1; aluData = 32'h1000_0001;
                loadValid = 1'b1; loadReg = 5'd7; loadData = 32'h11;
        @(negedge clk);
        check("fill_ready0", 37'(loadReady), 37'(1));
        tick(); aluReg = 5'd2; aluData = 32'h1000_0002; loadReg = 5'd8; loadData = 32'h22;
        @(negedge clk);
        check("fill_ready1", 37'(loadReady), 37'(1));
        tick(); aluReg = 5'd3; aluData = 32'h1000_0003; loadReg = 5'd9; loadData = 32'h33;
                queryReg1 = 5'd8;
        @(negedge clk);
        check("fill_full",   37'(loadReady), 37'(0));
        check("fill_hit8",   37'(queryHit1), 37'(1));
        check("fill_stall",  37'(aluStall),  37'(0));
        tick(); aluValid = 1'b0;
        @(negedge clk);
        check("drain_full",  37'(loadReady), 37'(0));
        tick();
        @(negedge clk);
        check("drain_ready", 37'(loadReady), 37'(1));
        tick(); loadValid = 1'b0;
        tick();
        @(negedge clk);
        check("drain_count", 37'(dut.count), 37'(0));
        tick();
        @(negedge clk);
        check("drain_idle",  37'(writeEnable), 37'(0));

        // Starvation: buffered load forced out on the 5th ALU cycle
        sb.push_back({5'd10, 32'hA10});
        sb.push_back({5'd11, 32'hA11});
        sb.push_back({5'd12, 32'hA12});
        sb.push_back({5'd13, 32'hA13});
        sb.push_back({5'd3,  32'h44});
        sb.push_back({5'd14, 32'hA14});
        tick(); loadValid = 1'b1; loadReg = 5'd3; loadData = 32'h44;
        tick(); loadValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            aluValid = 1'b1; aluReg = 5'(10 + k); aluData = 32'hA10 + 32'(k);
            @(negedge clk);
            check("starve_early", 37'(aluStall), 37'(0));
            tick();
        end
        aluReg = 5'd14; aluData = 32'hA14;
        @(negedge clk);
        check("starve_stall", 37'(aluStall), 37'(1));
        tick();
        @(negedge clk);
        check("starve_release", 37'(aluStall), 37'(0));
        check("starve_load",    {writeReg, writeData}, {5'd3, 32'h44});
        check("starve_wait0",   37'(dut.waitCount), 37'(0));
        tick(); aluValid = 1'b0;
        @(negedge clk);
        check("starve_held",    {writeReg, writeData}, {5'd14, 32'hA14});
        tick();

        // x0 suppression for both sources
        tick(); aluValid = 1'b1; aluReg = 5'd0; aluData = 32'h55;
                loadValid = 1'b1; loadReg = 5'd0; loadData = 32'h66;
        tick(); aluValid = 1'b0; loadValid = 1'b0; queryReg1 = 5'd0;
        @(negedge clk);
        check("x0_alu_we",   37'(writeEnable), 37'(0));
        check("x0_hit",      37'(queryHit1),   37'(0));
        check("x0_count1",   37'(dut.count),   37'(1));
        check("x0_wdata",    37'(writeData),   37'(0));
        tick();
        @(negedge clk);
        check("x0_load_we",  37'(writeEnable), 37'(0));
        check("x0_wreg",     37'(writeReg),    37'(0));
        check("x0_count0",   37'(dut.count),   37'(0));

        // Reset mid-operation discards buffered loads
        sb.push_back({5'd20, 32'hB0});
        sb.push_back({5'd22, 32'hB2});
        tick(); aluValid = 1'b1; aluReg = 5'd20; aluData = 32'hB0;
                loadValid = 1'b1; loadReg = 5'd21; loadData = 32'hC1;
        tick(); aluReg = 5'd22; aluData = 32'hB2; loadReg = 5'd23; loadData = 32'hC3;
        tick(); aluValid = 1'b0; loadValid = 1'b0; reset = 1'b1;
                queryReg1 = 5'd21; queryReg2 = 5'd23;
        @(negedge clk);
        check("mid_rst_hit1",  37'(queryHit1), 37'(0));
        check("mid_rst_ready", 37'(loadReady), 37'(0));
        tick(); reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 37'(loadReady),   37'(1));
        check("post_rst_count", 37'(dut.count),   37'(0));
        check("post_rst_hit2",  37'(queryHit2),   37'(0));
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            check("post_rst_we", 37'(writeEnable), 37'(0));
        end

        check("scoreboard_empty", 37'(sb.size()), 37'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
